// File: rtl/timer_bank_if.sv
// timer_bank_if -- configuration bus for timer_bank.
//   cfg_write    single-cycle strobe that loads the addressed channel
//   cfg_channel  channel index; indices >= channels are dropped
//   cfg_period   new period P (0 halts the channel)
//   cfg_toggle   new output mode: 0 = pulse, 1 = toggle
//   cfg_oneshot  new run mode: 0 = periodic, 1 = one-shot
// The master modport drives the bus and the slave modport (timer_bank) receives it.
interface timer_bank_if #(
  parameter int width = 16
);
  logic             cfg_write;
  logic [3:0]       cfg_channel;
  logic [width-1:0] cfg_period;
  logic             cfg_toggle;
  logic             cfg_oneshot;

  modport master (output cfg_write, cfg_channel, cfg_period, cfg_toggle, cfg_oneshot);
  modport slave  (input  cfg_write, cfg_channel, cfg_period, cfg_toggle, cfg_oneshot);
endinterface

// File: rtl/timer_bank.sv
// timer_bank -- bank of independent period counters with pulse/toggle output
// and periodic/one-shot run modes.
//   clock   sole clock, rising edge
//   reset   asynchronous, active-high; restores parameter defaults
//   enable  per-channel count enable
//   cfg     configuration bus (timer_bank_if.slave)
//   out     registered per-channel event output
//   done    registered per-channel one-shot-complete flag

// One channel: period, mode pair, counter, armed flag, out/done registers.
module timer_bank_chan #(
  parameter int width   = 16,
  parameter int count   = 1,
  parameter int toggle  = 0,
  parameter int oneshot = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [width-1:0] wr_period,
  input  logic             wr_toggle,
  input  logic             wr_oneshot,
  output logic             out,
  output logic             done
);
  logic [width-1:0] p_q, p_d, c_q, c_d;
  logic tog_q, tog_d, os_q, os_d, armed_q, armed_d, out_q, out_d, done_q, done_d;

  always_comb begin
    p_d     = p_q;
    c_d     = c_q;
    tog_d   = tog_q;
    os_d    = os_q;
    armed_d = armed_q;
    done_d  = done_q;
    // Pulse mode holds out high for one cycle only; toggle mode holds its level.
    out_d   = tog_q ? out_q : 1'b0;
    if (wr) begin
      // A write outranks a same-edge enable, so no terminal event is possible here.
      p_d     = wr_period;
      tog_d   = wr_toggle;
      os_d    = wr_oneshot;
      c_d     = '0;
      armed_d = 1'b1;
      done_d  = 1'b0;
      out_d   = wr_toggle ? out_q : 1'b0;
    end else if (en && armed_q && (p_q != '0)) begin
      if (c_q == p_q - 1'b1) begin
        c_d   = '0;
        out_d = tog_q ? ~out_q : 1'b1;
        if (os_q) begin
          armed_d = 1'b0;
          done_d  = 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_q     <= width'(count);
      c_q     <= '0;
      tog_q   <= (toggle != 0);
      os_q    <= (oneshot != 0);
      armed_q <= 1'b1;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      p_q     <= p_d;
      c_q     <= c_d;
      tog_q   <= tog_d;
      os_q    <= os_d;
      armed_q <= armed_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;
endmodule

module timer_bank #(
  parameter int channels = 4,
  parameter int width    = 16,
  parameter int count    = 1,
  parameter int toggle   = 0,
  parameter int oneshot  = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [channels-1:0] enable,
  timer_bank_if.slave         cfg,
  output logic [channels-1:0] out,
  output logic [channels-1:0] done
);
  for (genvar i = 0; i < channels; i++) begin : g_chan
    // Full 4-bit compare: indices at or above channels never alias a channel.
    logic wr;
    assign wr = cfg.cfg_write && (cfg.cfg_channel == 4'(i));

    timer_bank_chan #(
      .width(width), .count(count), .toggle(toggle), .oneshot(oneshot)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .en         (enable[i]),
      .wr         (wr),
      .wr_period  (cfg.cfg_period),
      .wr_toggle  (cfg.cfg_toggle),
      .wr_oneshot (cfg.cfg_oneshot),
      .out        (out[i]),
      .done       (done[i])
    );
  end
endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] enable;
  logic [3:0] out, done;
  int vecs = 0;
  int errs = 0;

  timer_bank_if #(.width(16)) cfg_if ();

  timer_bank dut (
    .clock (clock), .reset (reset), .enable (enable),
    .cfg (cfg_if), .out (out), .done (done)
  );

  always #5 clock = ~clock;

  // Advance one rising edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [3:0] ch, input logic [15:0] p,
                       input logic tg, input logic os, input logic [3:0] en);
    cfg_if.cfg_write   = 1'b1;
    cfg_if.cfg_channel = ch;
    cfg_if.cfg_period  = p;
    cfg_if.cfg_toggle  = tg;
    cfg_if.cfg_oneshot = os;
    enable = en;
    step();
    cfg_if.cfg_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = '0;
    cfg_if.cfg_write = 1'b0; cfg_if.cfg_channel = '0; cfg_if.cfg_period = '0;
    cfg_if.cfg_toggle = 1'b0; cfg_if.cfg_oneshot = 1'b0;
    step(); step();
    vecs++;
    if (out !== 4'b0000 || done !== 4'b0000) begin
      errs++; $display("FAIL reset: out=%b done=%b, want 0000/0000", out, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_default_p1();
    enable = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      step();
      vecs++;
      if (out !== 4'b0001) begin
        errs++; $display("FAIL p1_edge%0d: out=%b want 0001", k, out);
      end
    end
    enable = '0;
    step();
    vecs++;
    if (out !== 4'b0000) begin
      errs++; $display("FAIL p1_idle: out=%b want 0000", out);
    end
  endtask

  task automatic test_pulse();
    logic [3:0] exp;
    write(4'd1, 16'd5, 1'b0, 1'b0, 4'b0000);
    enable = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = (k % 5 == 0) ? 4'b0010 : 4'b0000;
      vecs++;
      if (out !== exp) begin
        errs++; $display("FAIL pulse_edge%0d: out=%b want %b", k, out, exp);
      end
    end
    enable = '0;
  endtask

  task automatic test_toggle();
    logic [3:0] exp;
    write(4'd2, 16'd3, 1'b1, 1'b0, 4'b0000);
    enable = 4'b0100;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = ((k / 3) % 2 == 1) ? 4'b0100 : 4'b0000;
      vecs++;
      if (out !== exp) begin
        errs++; $display("FAIL toggle_edge%0d: out=%b want %b", k, out, exp);
      end
    end
    enable = '0;
  endtask

  // ch2 is left in toggle mode at level 1 from here on.
  task automatic test_oneshot();
    write(4'd3, 16'd4, 1'b0, 1'b1, 4'b0000);
    enable = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      step();
      vecs++;
      if (out !== ((k == 4) ? 4'b1100 : 4'b0100) || done !== ((k >= 4) ? 4'b1000 : 4'b0000)) begin
        errs++; $display("FAIL oneshot_edge%0d: out=%b done=%b", k, out, done);
      end
    end
    write(4'd3, 16'd4, 1'b0, 1'b1, 4'b1000);
    vecs++;
    if (done !== 4'b0000 || out !== 4'b0100) begin
      errs++; $display("FAIL oneshot_rearm: done=%b out=%b want 0000/0100", done, out);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      vecs++;
      if (out[3] !== (k == 4) || done[3] !== (k == 4)) begin
        errs++; $display("FAIL oneshot_again%0d: out3=%b done3=%b", k, out[3], done[3]);
      end
    end
    enable = '0;
  endtask

  // ch1 sits at c=2 after the 12-enable pulse test.
  task automatic test_write_wins();
    enable = 4'b0010;
    step(); step();
    vecs++;
    if (out !== 4'b0100) begin
      errs++; $display("FAIL ww_precount: out=%b want 0100", out);
    end
    write(4'd1, 16'd5, 1'b0, 1'b0, 4'b0010);
    vecs++;
    if (out !== 4'b0100) begin
      errs++; $display("FAIL ww_same_edge: out=%b want 0100", out);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      vecs++;
      if (out !== ((k == 5) ? 4'b0110 : 4'b0100)) begin
        errs++; $display("FAIL ww_recount%0d: out=%b", k, out);
      end
    end
    write(4'd9, 16'd0, 1'b0, 1'b1, 4'b0000);
    vecs++;
    if (out !== 4'b0100 || done !== 4'b1000) begin
      errs++; $display("FAIL bad_index: out=%b done=%b want 0100/1000", out, done);
    end
    enable = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      step();
      vecs++;
      if (out !== ((k == 5) ? 4'b0110 : 4'b0100)) begin
        errs++; $display("FAIL bad_index_ch1_%0d: out=%b", k, out);
      end
    end
    enable = '0;
  endtask

  task automatic test_parallel();
    write(4'd0, 16'd2, 1'b0, 1'b0, 4'b0000);
    write(4'd1, 16'd2, 1'b0, 1'b0, 4'b0000);
    enable = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      step();
      vecs++;
      if (out[1:0] !== ((k % 2 == 0) ? 2'b11 : 2'b00)) begin
        errs++; $display("FAIL parallel%0d: out=%b", k, out);
      end
    end
    enable = '0;
  endtask

  task automatic test_reset_mid();
    enable = 4'b1111;
    step();
    #2 reset = 1'b1;
    #1;
    vecs++;
    if (out !== 4'b0000 || done !== 4'b0000) begin
      errs++; $display("FAIL async_reset: out=%b done=%b want 0000/0000", out, done);
    end
    step();
    reset = 1'b0;
    // ch1 is back to P=1, so it must fire on the very first edge after release.
    write(4'd0, 16'd0, 1'b0, 1'b0, 4'b0010);
    vecs++;
    if (out !== 4'b0010) begin
      errs++; $display("FAIL post_reset_first: out=%b want 0010", out);
    end
    enable = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      step();
      vecs++;
      if (out !== 4'b0010) begin
        errs++; $display("FAIL halt_ch0_%0d: out=%b want 0010", k, out);
      end
    end
    enable = '0;
  endtask

  initial begin
    test_reset();
    test_default_p1();
    test_pulse();
    test_toggle();
    test_oneshot();
    test_write_wins();
    test_parallel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
